// File: rtl/ps2_cmd_sequencer.sv
// ps2_cmd_sequencer: host-side PS/2 command scheduler.
// Sends opcode/argument, handles ACK/resend/BAT, forwards scancodes.
module ps2_cmd_sequencer #(
  parameter int ACK_TIMEOUT = 1_000_000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_code,
  input  logic       cmd_has_arg,
  input  logic [7:0] cmd_arg,
  output logic       tx_send,
  output logic [7:0] tx_byte,
  input  logic       tx_done,
  input  logic       tx_err,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       pass_valid,
  output logic [7:0] pass_data,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy
);
  localparam int TW = ($clog2(ACK_TIMEOUT) > 20) ? $clog2(ACK_TIMEOUT) : 20;
  localparam logic [TW-1:0] TMAX = TW'(ACK_TIMEOUT - 1);
  localparam logic [3:0] RMAX = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE, SEND_OP, SEND_ARG, WAIT_TX,
    WAIT_ACK, WAIT_BAT, DONE, ERR
  } state_t;

  state_t        state, state_n;
  logic [7:0]    op, op_n, arg, arg_n;
  logic          has_arg, has_arg_n;
  logic          arg_ph, arg_ph_n;
  logic [3:0]    retry, retry_n;
  logic [TW-1:0] tmr, tmr_n;
  logic          tx_send_n, done_n, err_n;
  logic          pass_valid_n, fwd;
  logic [7:0]    tx_byte_n, pass_data_n;
  logic [1:0]    err_code_n;
  logic          rx_ack, rx_rsnd, rx_bat, rx_bfail, expired;

  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;
  assign rx_ack    = rx_valid && (rx_data == 8'hFA);
  assign rx_rsnd   = rx_valid && (rx_data == 8'hFE);
  assign rx_bat    = rx_valid && (rx_data == 8'hAA);
  assign rx_bfail  = rx_valid && (rx_data == 8'hFC);
  assign expired   = (tmr == TMAX);

  always_comb begin
    state_n      = state;
    op_n         = op;
    arg_n        = arg;
    has_arg_n    = has_arg;
    arg_ph_n     = arg_ph;
    retry_n      = retry;
    tx_send_n    = 1'b0;
    tx_byte_n    = tx_byte;
    done_n       = 1'b0;
    err_n        = 1'b0;
    err_code_n   = err_code;
    fwd          = rx_valid;
    unique case (state)
      IDLE: if (cmd_valid) begin
        op_n       = cmd_code;
        arg_n      = cmd_arg;
        has_arg_n  = cmd_has_arg;
        arg_ph_n   = 1'b0;
        retry_n    = '0;
        err_code_n = 2'b00;
        state_n    = SEND_OP;
      end
      SEND_OP: begin
        tx_send_n = 1'b1;
        tx_byte_n = op;
        state_n   = WAIT_TX;
      end
      SEND_ARG: begin
        tx_send_n = 1'b1;
        tx_byte_n = arg;
        state_n   = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_err) begin
          state_n    = ERR;
          err_code_n = 2'b01;
        end else if (tx_done) begin
          state_n = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // a consumed byte in the expiry cycle beats the timeout
        if (rx_ack) begin
          fwd = 1'b0;
          if (!arg_ph && has_arg) begin
            arg_ph_n = 1'b1;
            retry_n  = '0;
            state_n  = SEND_ARG;
          end else if (!arg_ph && op == 8'hFF) begin
            state_n = WAIT_BAT;
          end else begin
            state_n = DONE;
          end
        end else if (rx_rsnd) begin
          fwd = 1'b0;
          if (retry < RMAX) begin
            retry_n = retry + 4'd1;
            state_n = arg_ph ? SEND_ARG : SEND_OP;
          end else begin
            state_n    = ERR;
            err_code_n = 2'b11;
          end
        end else if (expired) begin
          state_n    = ERR;
          err_code_n = 2'b10;
        end
      end
      WAIT_BAT: begin
        if (rx_bat) begin
          fwd     = 1'b0;
          state_n = DONE;
        end else if (rx_bfail) begin
          fwd        = 1'b0;
          state_n    = ERR;
          err_code_n = 2'b11;
        end else if (expired) begin
          state_n    = ERR;
          err_code_n = 2'b10;
        end
      end
      DONE: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      ERR: begin
        err_n   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    pass_valid_n = fwd;
    pass_data_n  = fwd ? rx_data : pass_data;
    // timer restarts on every state change
    if ((state == WAIT_ACK || state == WAIT_BAT) && state_n == state)
      tmr_n = tmr + 1'b1;
    else
      tmr_n = '0;
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      op         <= '0;
      arg        <= '0;
      has_arg    <= 1'b0;
      arg_ph     <= 1'b0;
      retry      <= '0;
      tmr        <= '0;
      tx_send    <= 1'b0;
      tx_byte    <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= '0;
      pass_valid <= 1'b0;
      pass_data  <= '0;
    end else begin
      state      <= state_n;
      op         <= op_n;
      arg        <= arg_n;
      has_arg    <= has_arg_n;
      arg_ph     <= arg_ph_n;
      retry      <= retry_n;
      tmr        <= tmr_n;
      tx_send    <= tx_send_n;
      tx_byte    <= tx_byte_n;
      done       <= done_n;
      err        <= err_n;
      err_code   <= err_code_n;
      pass_valid <= pass_valid_n;
      pass_data  <= pass_data_n;
    end
  end
endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// tb_ps2_cmd_sequencer: randomized bench acting as PS/2 engine and keyboard.
// Expected tx bytes, forwarded bytes and outcomes are queued from protocol rules.
module tb_ps2_cmd_sequencer;
  localparam int TO = 100;
  localparam int MR = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_has_arg;
  logic [7:0] cmd_code, cmd_arg;
  logic       tx_send, tx_done, tx_err;
  logic [7:0] tx_byte;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       pass_valid;
  logic [7:0] pass_data;
  logic       done, err, busy;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  ps2_cmd_sequencer #(.ACK_TIMEOUT(TO), .MAX_RETRY(MR)) dut (
    .CLOCK_50(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_code(cmd_code), .cmd_has_arg(cmd_has_arg), .cmd_arg(cmd_arg),
    .tx_send(tx_send), .tx_byte(tx_byte),
    .tx_done(tx_done), .tx_err(tx_err),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .pass_valid(pass_valid), .pass_data(pass_data),
    .done(done), .err(err), .err_code(err_code), .busy(busy)
  );

  typedef struct { bit is_err; int code; int at; } out_t;
  typedef struct { int d; int at; } pass_t;

  out_t  exp_out[$];
  pass_t exp_pass[$];
  int    exp_tx[$];

  int cyc = 0;
  int n_chk = 0, n_pass = 0;
  int n_tx = 0, n_done = 0, n_err = 0, n_pv = 0;
  int acc_cyc = 0, last_err_cyc = 0, last_tdone = 0;
  bit first_tx = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
                  nm, act, act, exp, exp, cyc);
  endtask

  task automatic exp_o(input bit e, input int c, input int at);
    out_t o;
    o.is_err = e; o.code = c; o.at = at;
    exp_out.push_back(o);
  endtask

  always @(negedge clk) begin
    out_t  o;
    pass_t q;
    int    e;
    if (!reset) begin
      if (cmd_valid && cmd_ready) begin
        acc_cyc  = cyc;
        first_tx = 1;
      end
      if (tx_send) begin
        n_tx++;
        if (exp_tx.size() == 0) chk("tx_extra", 1, 0);
        else begin
          e = exp_tx.pop_front();
          chk("tx_byte", int'(tx_byte), e);
        end
        chk("busy_tx", int'(busy), 1);
        if (first_tx) begin
          chk("accept_latency", cyc - acc_cyc, 2);
          first_tx = 0;
        end
      end
      if (pass_valid) begin
        n_pv++;
        if (exp_pass.size() == 0) chk("pass_extra", int'(pass_data), -1);
        else begin
          q = exp_pass.pop_front();
          chk("pass_data", int'(pass_data), q.d);
          chk("pass_cycle", cyc, q.at);
        end
      end
      if (done || err) begin
        if (done) n_done++;
        if (err) begin n_err++; last_err_cyc = cyc; end
        if (exp_out.size() == 0) chk("outcome_extra", int'({done, err}), 0);
        else begin
          o = exp_out.pop_front();
          chk("outcome_err", int'(err), int'(o.is_err));
          chk("outcome_done", int'(done), int'(!o.is_err));
          chk("outcome_code", int'(err_code), o.is_err ? o.code : 0);
          chk("outcome_cycle", cyc, o.at);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rx(input logic [7:0] b, input bit fwd, output int at);
    tick();
    rx_valid = 1'b1; rx_data = b; at = cyc;
    if (fwd) begin
      pass_t q;
      q.d = int'(b); q.at = cyc + 1;
      exp_pass.push_back(q);
    end
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic junk(input int n);
    int t;
    for (int i = 0; i < n; i++) rx(8'($urandom_range(0, 127)), 1'b1, t);
  endtask

  task automatic pulse_done(output int at);
    tick(); tx_done = 1'b1; at = cyc; last_tdone = cyc;
    tick(); tx_done = 1'b0;
  endtask

  task automatic pulse_err(output int at);
    tick(); tx_err = 1'b1; at = cyc;
    tick(); tx_err = 1'b0;
  endtask

  task automatic wait_tx(output bit ok);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_send) begin ok = 1; break; end
    end
    if (!ok) chk("tx_wait_timeout", 0, 1);
  endtask

  task automatic issue(input logic [7:0] c, input bit h, input logic [7:0] a,
                       output bit ok);
    tick();
    cmd_valid = 1'b1; cmd_code = c; cmd_has_arg = h; cmd_arg = a;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    tick();
    cmd_valid = 1'b0;
    cmd_code = 8'($urandom); cmd_arg = 8'($urandom);
    cmd_has_arg = 1'($urandom);
  endtask

  // mode: 0 random resends, 1 exhaust opcode retries, 2 tx_err on last byte,
  // 3 timeout on last byte, 4 BAT failure, 5 clean, 6 two opcode resends
  task automatic do_cmd(input logic [7:0] code, input bit has,
                        input logic [7:0] arg, input int mode);
    bit ok;
    int t, k, nb;
    logic [7:0] b;
    nb = has ? 2 : 1;
    t = 0;
    issue(code, has, arg, ok);
    if (!ok) return;
    for (int p = 0; p < nb; p++) begin
      b = (p != 0) ? arg : code;
      k = 0;
      forever begin
        exp_tx.push_back(int'(b));
        wait_tx(ok);
        if (!ok) return;
        junk($urandom_range(0, 1));
        if (mode == 2 && p == nb - 1) begin
          pulse_err(t);
          exp_o(1, 1, t + 2);
          return;
        end
        pulse_done(t);
        junk($urandom_range(0, 2));
        if (mode == 3 && p == nb - 1) begin
          exp_o(1, 2, t + TO + 2);
          return;
        end
        if ((mode == 1 && p == 0) || (mode == 6 && p == 0 && k < 2) ||
            (mode == 0 && k < MR && $urandom_range(0, 3) == 0)) begin
          k++;
          rx(8'hFE, 1'b0, t);
          if (k > MR) begin
            exp_o(1, 3, t + 2);
            return;
          end
        end else begin
          rx(8'hFA, 1'b0, t);
          break;
        end
      end
    end
    if (code == 8'hFF) begin
      junk($urandom_range(0, 2));
      if (mode == 4) begin
        rx(8'hFC, 1'b0, t);
        exp_o(1, 3, t + 2);
      end else begin
        rx(8'hAA, 1'b0, t);
        exp_o(0, 0, t + 2);
      end
    end else begin
      exp_o(0, 0, t + 2);
    end
  endtask

  task automatic settle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cmd_ready && exp_out.size() == 0) begin ok = 1; break; end
    end
    if (!ok) chk("settle_timeout", 0, 1);
    repeat (3) tick();
    chk("txq_empty", exp_tx.size(), 0);
    chk("outq_empty", exp_out.size(), 0);
    chk("passq_empty", exp_pass.size(), 0);
  endtask

  initial begin
    int t, r, tx0, d0, e0, p0;
    bit ok;
    logic [7:0] c;
    int mode;
    reset = 1'b1;
    cmd_valid = 0; cmd_code = 0; cmd_has_arg = 0; cmd_arg = 0;
    tx_done = 0; tx_err = 0; rx_valid = 0; rx_data = 0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tx_send", int'(tx_send), 0);
    chk("rst_tx_byte", int'(tx_byte), 0);
    chk("rst_done_err", int'({done, err}), 0);
    chk("rst_pass", int'({pass_valid, pass_data}), 0);
    chk("rst_err_code", int'(err_code), 0);
    tick();
    reset = 1'b0;
    repeat (2) tick();

    tx0 = n_tx; d0 = n_done; e0 = n_err;
    do_cmd(8'hF4, 0, 8'h00, 5);
    settle();
    chk("f4_tx_count", n_tx - tx0, 1);
    chk("f4_done_count", n_done - d0, 1);
    chk("f4_err_count", n_err - e0, 0);

    tx0 = n_tx; d0 = n_done;
    do_cmd(8'hED, 1, 8'h07, 5);
    settle();
    chk("ed_tx_count", n_tx - tx0, 2);
    chk("ed_done_count", n_done - d0, 1);

    tx0 = n_tx; d0 = n_done;
    do_cmd(8'hED, 1, 8'h02, 6);
    settle();
    chk("resend_tx_count", n_tx - tx0, 4);
    chk("resend_done_count", n_done - d0, 1);

    tx0 = n_tx; e0 = n_err;
    do_cmd(8'hED, 1, 8'h07, 1);
    settle();
    chk("exhaust_tx_count", n_tx - tx0, 4);
    chk("exhaust_err_count", n_err - e0, 1);
    chk("exhaust_code", int'(err_code), 3);

    do_cmd(8'hF4, 0, 8'h00, 3);
    settle();
    chk("timeout_delay", last_err_cyc - last_tdone, 102);
    chk("timeout_code_held", int'(err_code), 2);

    issue(8'hF4, 0, 8'h00, ok);
    exp_tx.push_back(8'hF4);
    wait_tx(ok);
    pulse_done(t);
    while (cyc < t + TO - 1) tick();
    rx(8'hFA, 1'b0, r);
    exp_o(0, 0, r + 2);
    chk("ack_at_expiry_cycle", r - t, TO);
    settle();
    chk("ack_at_expiry_code", int'(err_code), 0);

    d0 = n_done; p0 = n_pv;
    issue(8'hFF, 0, 8'h00, ok);
    exp_tx.push_back(8'hFF);
    wait_tx(ok);
    pulse_done(t);
    rx(8'h1C, 1'b1, r);
    rx(8'hFA, 1'b0, r);
    rx(8'hAA, 1'b0, r);
    exp_o(0, 0, r + 2);
    settle();
    chk("bat_pass_count", n_pv - p0, 1);
    chk("bat_pass_data", int'(pass_data), 8'h1C);
    chk("bat_done_count", n_done - d0, 1);

    do_cmd(8'hF4, 0, 8'h00, 2);
    settle();
    chk("txerr_code", int'(err_code), 1);

    d0 = n_done; e0 = n_err;
    issue(8'hF4, 0, 8'h00, ok);
    exp_tx.push_back(8'hF4);
    wait_tx(ok);
    pulse_done(t);
    repeat (2) tick();
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_ready", int'(cmd_ready), 1);
    chk("midrst_pulses", int'({tx_send, done, err}), 0);
    tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("midrst_ready_after", int'(cmd_ready), 1);
    chk("midrst_no_done", n_done - d0, 0);
    chk("midrst_no_err", n_err - e0, 0);
    settle();

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: c = 8'hF4;
        1: c = 8'hED;
        2: c = 8'hFF;
        3: c = 8'hF3;
        default: c = 8'($urandom_range(0, 8'hFE));
      endcase
      mode = 0;
      case ($urandom_range(0, 9))
        0: mode = 1;
        1: mode = 2;
        2: mode = 3;
        3: mode = (c == 8'hFF) ? 4 : 0;
        default: mode = 0;
      endcase
      junk($urandom_range(0, 1));
      do_cmd(c, (c != 8'hFF) && ($urandom_range(0, 1) == 1),
             8'($urandom), mode);
      settle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
